// File: rtl/uart_rx_word_packer.sv
// Packs UART receiver bytes little-endian into 32-bit words and queues them in a
// first-word-fall-through FIFO; backpressures the receiver by withholding the byte ack.
module uart_rx_word_packer #(
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_byte_valid,
    input  logic [7:0]    rx_byte,
    input  logic          rx_frame_err,
    output logic          rx_byte_ack,
    output logic          word_valid,
    output logic [31:0]   word_data,
    input  logic          word_ready,
    output logic [LW-1:0] fifo_level,
    output logic [1:0]    byte_cnt,
    output logic          frame_err_sticky,
    input  logic          clr_err
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    logic [1:0]    state;
    logic [7:0]    lane0, lane1, lane2, hold;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          full, empty, push, pop;
    logic          byte_in, err_in;
    logic [31:0]   push_data;

    // Full is taken from the registered level, so a same-cycle pop never frees space.
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    assign err_in  = (state == S_IDLE) && rx_frame_err;
    assign byte_in = (state == S_IDLE) && rx_byte_valid && !rx_frame_err;
    assign pop     = word_ready && !empty;

    always_comb begin
        push      = 1'b0;
        push_data = {rx_byte, lane2, lane1, lane0};
        if (byte_in && byte_cnt == 2'd3 && !full) begin
            push = 1'b1;
        end
        if (state == S_STALL && !full) begin
            push      = 1'b1;
            push_data = {hold, lane2, lane1, lane0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            byte_cnt         <= 2'd0;
            lane0            <= 8'd0;
            lane1            <= 8'd0;
            lane2            <= 8'd0;
            hold             <= 8'd0;
            frame_err_sticky <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (err_in) begin
                        byte_cnt <= 2'd0;
                        lane0    <= 8'd0;
                        lane1    <= 8'd0;
                        lane2    <= 8'd0;
                    end else if (byte_in) begin
                        if (byte_cnt != 2'd3) begin
                            case (byte_cnt)
                                2'd0:    lane0 <= rx_byte;
                                2'd1:    lane1 <= rx_byte;
                                default: lane2 <= rx_byte;
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
                            state    <= S_ACK;
                        end else if (!full) begin
                            byte_cnt <= 2'd0;
                            state    <= S_ACK;
                        end else begin
                            hold  <= rx_byte;
                            state <= S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    if (!full) begin
                        byte_cnt <= 2'd0;
                        state    <= S_ACK;
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (err_in) begin
                frame_err_sticky <= 1'b1;
            end else if (clr_err) begin
                frame_err_sticky <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; word_data is forced to 0 while empty, so stale
    // entries are never observable and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    assign rx_byte_ack = (state == S_ACK);
    assign word_valid  = !empty;
    assign word_data   = empty ? 32'd0 : mem[rd_ptr];
    assign fifo_level  = level;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer: a byte-packing model feeds a word queue that
// a negedge monitor pops and compares whenever the DUT hands a word to the consumer.
`timescale 1ns/1ps
module tb_uart_rx_word_packer;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_byte_valid = 1'b0;
    logic [7:0]    rx_byte = 8'd0;
    logic          rx_frame_err = 1'b0;
    logic          rx_byte_ack;
    logic          word_valid;
    logic [31:0]   word_data;
    logic          word_ready = 1'b0;
    logic [LW-1:0] fifo_level;
    logic [1:0]    byte_cnt;
    logic          frame_err_sticky;
    logic          clr_err = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  m_lane[3];
    int          m_cnt = 0;
    logic        valid_t1;
    logic [31:0] data_t1;

    uart_rx_word_packer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_byte_valid    (rx_byte_valid),
        .rx_byte          (rx_byte),
        .rx_frame_err     (rx_frame_err),
        .rx_byte_ack      (rx_byte_ack),
        .word_valid       (word_valid),
        .word_data        (word_data),
        .word_ready       (word_ready),
        .fifo_level       (fifo_level),
        .byte_cnt         (byte_cnt),
        .frame_err_sticky (frame_err_sticky),
        .clr_err          (clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Consumer-side scoreboard: every handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            check(32'(int'(fifo_level) <= DEPTH), 32'd1, "level_le_depth");
            if (word_valid && word_ready) begin
                check(32'(exp_q.size() != 0), 32'd1, "pop_with_model_empty");
                if (exp_q.size() != 0) begin
                    check(word_data, exp_q.pop_front(), "word_order");
                end
            end
        end
    end

    task automatic model_byte(input logic [7:0] b);
        if (m_cnt == 3) begin
            exp_q.push_back({b, m_lane[2], m_lane[1], m_lane[0]});
            m_cnt = 0;
        end else begin
            m_lane[m_cnt] = b;
            m_cnt++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        @(posedge clk); #1;
        rx_byte_valid = 1'b1;
        rx_byte       = b;
        model_byte(b);
        @(posedge clk); #1;
        rx_byte_valid = 1'b0;
        valid_t1      = word_valid;
        data_t1       = word_data;
        check(32'(rx_byte_ack), 32'(exp_ack), {tag, "_ack_t1"});
        @(posedge clk); #1;
        check(32'(rx_byte_ack), 32'd0, {tag, "_ack_t2"});
    endtask

    task automatic drain(input string tag);
        word_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (fifo_level == '0) break;
        end
        check(32'(fifo_level), 32'd0, {tag, "_level"});
        check(32'(exp_q.size()), 32'd0, {tag, "_model_empty"});
    endtask

    task automatic check_reset_outputs(input string tag);
        check(32'(rx_byte_ack), 32'd0, {tag, "_ack"});
        check(32'(word_valid), 32'd0, {tag, "_valid"});
        check(word_data, 32'd0, {tag, "_data"});
        check(32'(fifo_level), 32'd0, {tag, "_level"});
        check(32'(byte_cnt), 32'd0, {tag, "_cnt"});
        check(32'(frame_err_sticky), 32'd0, {tag, "_sticky"});
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic word, consumer always ready
        word_ready = 1'b1;
        send_byte(8'h11, 1'b1, "b11");
        send_byte(8'h22, 1'b1, "b22");
        send_byte(8'h33, 1'b1, "b33");
        send_byte(8'h44, 1'b1, "b44");
        check(32'(valid_t1), 32'd1, "basic_valid_t1");
        check(data_t1, 32'h4433_2211, "basic_data_t1");
        check(32'(fifo_level), 32'd0, "basic_level_after_pop");

        // Fill FIFO, then stall on the next completed word
        word_ready = 1'b0;
        for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(8'h80 + i), 1'b1, "fill");
        check(32'(fifo_level), DEPTH, "fill_level");
        send_byte(8'hA0, 1'b1, "pre_stall0");
        send_byte(8'hA1, 1'b1, "pre_stall1");
        check(32'(byte_cnt), 32'd2, "pre_stall_cnt2");
        send_byte(8'hA2, 1'b1, "pre_stall2");
        send_byte(8'hA3, 1'b0, "stall_byte");
        repeat (3) @(posedge clk);
        #1;
        check(32'(rx_byte_ack), 32'd0, "stall_no_ack");
        check(32'(byte_cnt), 32'd3, "stall_cnt");
        check(32'(fifo_level), DEPTH, "stall_level");
        @(posedge clk); #1;
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        check(32'(rx_byte_ack), 32'd0, "stall_pop_cycle_no_ack");
        @(posedge clk); #1;
        check(32'(rx_byte_ack), 32'd1, "stall_release_ack");
        check(32'(fifo_level), DEPTH, "stall_release_level");
        check(32'(byte_cnt), 32'd0, "stall_release_cnt");
        @(posedge clk); #1;
        check(32'(rx_byte_ack), 32'd0, "stall_release_ack_once");
        drain("drain1");

        // Frame error discards partial word
        send_byte(8'hAA, 1'b1, "bAA");
        send_byte(8'hBB, 1'b1, "bBB");
        @(posedge clk); #1;
        rx_frame_err = 1'b1;
        m_cnt = 0;
        @(posedge clk); #1;
        rx_frame_err = 1'b0;
        check(32'(byte_cnt), 32'd0, "ferr_cnt");
        check(32'(frame_err_sticky), 32'd1, "ferr_sticky");
        check(32'(rx_byte_ack), 32'd0, "ferr_no_ack");
        check(32'(fifo_level), 32'd0, "ferr_no_push");
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, "after_err");
        check(data_t1, 32'h0403_0201, "after_err_word");
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check(32'(frame_err_sticky), 32'd0, "clr_err");
        @(posedge clk); #1;
        clr_err      = 1'b1;
        rx_frame_err = 1'b1;
        @(posedge clk); #1;
        clr_err      = 1'b0;
        rx_frame_err = 1'b0;
        check(32'(frame_err_sticky), 32'd1, "set_wins");

        // Error coincident with a byte drops the byte
        send_byte(8'h5A, 1'b1, "b5A");
        @(posedge clk); #1;
        rx_byte_valid = 1'b1;
        rx_byte       = 8'h5B;
        rx_frame_err  = 1'b1;
        m_cnt = 0;
        @(posedge clk); #1;
        rx_byte_valid = 1'b0;
        rx_frame_err  = 1'b0;
        check(32'(rx_byte_ack), 32'd0, "err_wins_no_ack");
        check(32'(byte_cnt), 32'd0, "err_wins_cnt");

        // Ordering across pointer wrap: start full, then stream with ready high
        word_ready = 1'b0;
        for (int w = 0; w < DEPTH; w++)
            for (int k = 0; k < 4; k++) send_byte(8'(4 * w + k + 1), 1'b1, "wrap_fill");
        check(32'(fifo_level), DEPTH, "wrap_full");
        word_ready = 1'b1;
        for (int w = DEPTH; w < 4 * DEPTH; w++)
            for (int k = 0; k < 4; k++) send_byte(8'(4 * w + k + 1), 1'b1, "wrap_stream");
        drain("drain_wrap");

        // Async reset while stalled with a partial word held
        word_ready = 1'b0;
        for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(8'hC0 + i), 1'b1, "rst_fill");
        send_byte(8'hE0, 1'b1, "rst_p0");
        send_byte(8'hE1, 1'b1, "rst_p1");
        send_byte(8'hE2, 1'b1, "rst_p2");
        send_byte(8'hE3, 1'b0, "rst_stall");
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        word_ready = 1'b1;
        send_byte(8'h71, 1'b1, "fresh0");
        send_byte(8'h72, 1'b1, "fresh1");
        send_byte(8'h73, 1'b1, "fresh2");
        send_byte(8'h74, 1'b1, "fresh3");
        check(32'(valid_t1), 32'd1, "fresh_valid");
        check(data_t1, 32'h7473_7271, "fresh_word");
        drain("drain_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
